// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory and decode-side handshake bundle for fetch_stage
interface fetch_stage_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      op_code;
   logic            out_misalign;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, op_code, out_misalign,
      input  imem_gnt, imem_rvalid, imem_rdata, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, op_code, out_misalign,
      output imem_gnt, imem_rvalid, imem_rdata, out_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch stage with redirect flush
// Optional misaligned-redirect trap build: define FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   fetch_stage_if.master   bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_FULL = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            kill_q, kill_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [XLEN-1:0] redirect_target;
   logic            outstanding;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic            mis_q, mis_d;
   logic            redirect_mis;

   assign redirect_target = redirect_pc;
   assign redirect_mis    = |redirect_pc[1:0];
`else
   assign redirect_target = redirect_pc & WORD_MASK;
`endif

   // A request is in flight past this cycle if it was granted now or is still waiting for data.
   assign outstanding = ((state_q == S_WAIT) && !bus.imem_rvalid) ||
                        ((state_q == S_REQ) && bus.imem_gnt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         kill_q   <= 1'b0;
         instr_q  <= '0;
         out_pc_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         mis_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         kill_q   <= kill_d;
         instr_q  <= instr_d;
         out_pc_q <= out_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         mis_q    <= mis_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      kill_d   = kill_q;
      instr_d  = instr_q;
      out_pc_d = out_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_d    = mis_q;
`endif

      // A trap redirect can leave the killed response to land outside WAIT.
      if (kill_q && bus.imem_rvalid && (state_q != S_WAIT)) begin
         kill_d = 1'b0;
      end

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (bus.imem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  instr_d  = bus.imem_rdata;
                  out_pc_d = pc_q;
                  state_d  = S_FULL;
               end
            end
         end
         S_FULL: begin
            if (bus.out_ready) begin
               pc_d    = pc_q + PC_STEP;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (redirect) begin
         pc_d    = redirect_target;
         instr_d = instr_q;
         if (outstanding) begin
            kill_d = 1'b1;
         end
         state_d = outstanding ? S_WAIT : S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
         mis_d = 1'b0;
         if (redirect_mis) begin
            state_d  = S_FULL;
            instr_d  = '0;
            out_pc_d = redirect_pc;
            mis_d    = 1'b1;
         end
`endif
      end
   end

   assign bus.imem_req  = (state_q == S_REQ);
   assign bus.imem_addr = pc_q & WORD_MASK;
   assign bus.out_valid = (state_q == S_FULL);
   assign bus.out_instr = instr_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.op_code   = instr_q[6:0];
`ifdef FETCH_MISALIGN_TRAP_EN
   assign bus.out_misalign = mis_q;
`else
   assign bus.out_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
   logic        clk;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   int          passed;
   int          total;

   fetch_stage_if #(.XLEN(32)) bus ();

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_word(input logic [31:0] data);
      bus.imem_gnt = 1'b1;
      step();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data;
      step();
      bus.imem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else passed++;
      total++; if (bus.out_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", bus.out_instr); else passed++;
      total++; if (bus.out_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", bus.out_pc); else passed++;
      total++; if (bus.out_misalign !== 1'b0) $display("FAIL reset_mis: got %b want 0", bus.out_misalign); else passed++;
      rst_n = 1'b1;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", bus.imem_req); else passed++;
      step();
      total++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", bus.imem_req); else passed++;
      total++; if (bus.imem_addr !== 32'h0) $display("FAIL first_addr: got %h want 0", bus.imem_addr); else passed++;
   endtask

   task automatic test_straight_line();
      bus.imem_gnt = 1'b1;
      step();
      bus.imem_gnt = 1'b0;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL wait_req: got %b want 0", bus.imem_req); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL wait_valid: got %b want 0", bus.out_valid); else passed++;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h0050_0093;
      step();
      bus.imem_rvalid = 1'b0;
      total++; if (bus.out_valid !== 1'b1) $display("FAIL sl_valid: got %b want 1", bus.out_valid); else passed++;
      total++; if (bus.out_instr !== 32'h0050_0093) $display("FAIL sl_instr: got %h want 00500093", bus.out_instr); else passed++;
      total++; if (bus.op_code !== 7'b0010011) $display("FAIL sl_opcode: got %b want 0010011", bus.op_code); else passed++;
      total++; if (bus.out_pc !== 32'h0) $display("FAIL sl_pc: got %h want 0", bus.out_pc); else passed++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      total++; if (bus.imem_req !== 1'b1) $display("FAIL sl_next_req: got %b want 1", bus.imem_req); else passed++;
      total++; if (bus.imem_addr !== 32'h4) $display("FAIL sl_next_addr: got %h want 4", bus.imem_addr); else passed++;
   endtask

   task automatic test_backpressure();
      fetch_word(32'h00A0_0113);
      for (int i = 0; i < 5; i++) begin
         total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); else passed++;
         total++; if (bus.out_instr !== 32'h00A0_0113) $display("FAIL bp_instr[%0d]: got %h want 00a00113", i, bus.out_instr); else passed++;
         total++; if (bus.out_pc !== 32'h4) $display("FAIL bp_pc[%0d]: got %h want 4", i, bus.out_pc); else passed++;
         total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_req[%0d]: got %b want 0", i, bus.imem_req); else passed++;
         step();
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      total++; if (bus.imem_addr !== 32'h8) $display("FAIL bp_next_addr: got %h want 8", bus.imem_addr); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drop_valid: got %b want 0", bus.out_valid); else passed++;
   endtask

   task automatic test_redirect_wait();
      bus.imem_gnt = 1'b1;
      step();
      bus.imem_gnt = 1'b0;
      redirect     = 1'b1;
      redirect_pc  = 32'h0000_0100;
      step();
      redirect = 1'b0;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL rw_req: got %b want 0", bus.imem_req); else passed++;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      step();
      bus.imem_rvalid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL rw_stale_valid: got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.imem_req !== 1'b1) $display("FAIL rw_rereq: got %b want 1", bus.imem_req); else passed++;
      total++; if (bus.imem_addr !== 32'h100) $display("FAIL rw_addr: got %h want 100", bus.imem_addr); else passed++;
      fetch_word(32'h0000_0037);
      total++; if (bus.out_instr !== 32'h0000_0037) $display("FAIL rw_instr: got %h want 00000037", bus.out_instr); else passed++;
      total++; if (bus.out_pc !== 32'h100) $display("FAIL rw_pc: got %h want 100", bus.out_pc); else passed++;
      total++; if (bus.op_code !== 7'b0110111) $display("FAIL rw_opcode: got %b want 0110111", bus.op_code); else passed++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      total++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", bus.imem_addr); else passed++;
      fetch_word(32'h0000_0013);
      total++; if (bus.out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h want fffffffc", bus.out_pc); else passed++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      total++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_next: got %h want 0", bus.imem_addr); else passed++;
   endtask

   task automatic test_redirect_full();
      fetch_word(32'h0000_0093);
      bus.out_ready = 1'b1;
      redirect      = 1'b1;
      redirect_pc   = 32'h0000_0200;
      step();
      bus.out_ready = 1'b0;
      redirect      = 1'b0;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL rf_valid: got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.imem_addr !== 32'h200) $display("FAIL rf_addr: got %h want 200", bus.imem_addr); else passed++;
   endtask

   task automatic test_redirect_gnt();
      bus.imem_gnt = 1'b1;
      redirect     = 1'b1;
      redirect_pc  = 32'h0000_0300;
      step();
      bus.imem_gnt = 1'b0;
      redirect     = 1'b0;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL rg_req: got %b want 0", bus.imem_req); else passed++;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      step();
      bus.imem_rvalid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL rg_valid: got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.imem_addr !== 32'h300) $display("FAIL rg_addr: got %h want 300", bus.imem_addr); else passed++;
   endtask

   task automatic test_misalign();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      step();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      total++; if (bus.out_valid !== 1'b1) $display("FAIL mis_valid: got %b want 1", bus.out_valid); else passed++;
      total++; if (bus.out_instr !== 32'h0) $display("FAIL mis_instr: got %h want 0", bus.out_instr); else passed++;
      total++; if (bus.out_misalign !== 1'b1) $display("FAIL mis_flag: got %b want 1", bus.out_misalign); else passed++;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL mis_req: got %b want 0", bus.imem_req); else passed++;
      total++; if (bus.out_pc !== 32'h102) $display("FAIL mis_pc: got %h want 102", bus.out_pc); else passed++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      redirect      = 1'b1;
      redirect_pc   = 32'h0000_0000;
      step();
      redirect = 1'b0;
      total++; if (bus.out_misalign !== 1'b0) $display("FAIL mis_clear: got %b want 0", bus.out_misalign); else passed++;
      total++; if (bus.imem_addr !== 32'h0) $display("FAIL mis_clear_addr: got %h want 0", bus.imem_addr); else passed++;
`else
      total++; if (bus.imem_req !== 1'b1) $display("FAIL mis_req: got %b want 1", bus.imem_req); else passed++;
      total++; if (bus.imem_addr !== 32'h100) $display("FAIL mis_addr: got %h want 100", bus.imem_addr); else passed++;
      total++; if (bus.out_misalign !== 1'b0) $display("FAIL mis_flag: got %b want 0", bus.out_misalign); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL mis_valid: got %b want 0", bus.out_valid); else passed++;
`endif
   endtask

   initial begin
      passed          = 0;
      total           = 0;
      rst_n           = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = 32'h0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.out_ready   = 1'b0;
      test_reset();
      test_straight_line();
      test_backpressure();
      test_redirect_wait();
      test_wrap();
      test_redirect_full();
      test_redirect_gnt();
      test_misalign();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
